// File: rtl/ldst_response_unit.sv
// ---------------------------------------------------------------------------
// ldst_response_unit
//
// Bridges single load/store requests from the execute stage onto the data
// bus and returns one completion pulse per accepted request. Requests that
// violate natural alignment can be faulted locally without touching the bus.
// Pipeline flushes abandon the request; a flush that lands while a bus access
// is outstanding parks the unit in DRAIN until the bus completes, so a stale
// completion can never be mistaken for a later request.
//
// Ports
//   iCLOCK, inRESET             clock, synchronous active-low reset
//   iRESET_SYNC, iEVENT_HOLD,
//   iEVENT_END                  flush controls (any one flushes)
//   iLDST_*                     request from execute (strobe + fields)
//   oLDST_BUSY                  unit cannot accept a request
//   oLDST_VALID/DATA/FAULT      completion pulse, load data, alignment fault
//   oDATA_REQ, iDATA_BUSY       bus request handshake
//   oDATA_*                     request fields held for the bus
//   iDATA_VALID, iDATA_DATA     bus completion and read data
// ---------------------------------------------------------------------------
module ldst_response_unit #(
    parameter int P_MISALIGN_CHECK = 1
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    // flush controls
    input  logic        iRESET_SYNC,
    input  logic        iEVENT_HOLD,
    input  logic        iEVENT_END,
    // execute-stage request
    input  logic        iLDST_REQ,
    output logic        oLDST_BUSY,
    input  logic        iLDST_RW,
    input  logic [31:0] iLDST_PDT,
    input  logic [31:0] iLDST_ADDR,
    input  logic [31:0] iLDST_DATA,
    input  logic [1:0]  iLDST_ORDER,
    input  logic [3:0]  iLDST_MASK,
    input  logic [13:0] iLDST_ASID,
    input  logic [1:0]  iLDST_MMUMOD,
    input  logic [2:0]  iLDST_MMUPS,
    // completion to execute stage
    output logic        oLDST_VALID,
    output logic [31:0] oLDST_DATA,
    output logic        oLDST_FAULT,
    // data bus request
    output logic        oDATA_REQ,
    input  logic        iDATA_BUSY,
    output logic        oDATA_RW,
    output logic [31:0] oDATA_PDT,
    output logic [31:0] oDATA_ADDR,
    output logic [31:0] oDATA_DATA,
    output logic [3:0]  oDATA_MASK,
    output logic [13:0] oDATA_ASID,
    output logic [1:0]  oDATA_MMUMOD,
    output logic [2:0]  oDATA_MMUPS,
    // data bus completion
    input  logic        iDATA_VALID,
    input  logic [31:0] iDATA_DATA
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_RESP  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    // Natural alignment: halves need an even address, words (order 2 and 3)
    // need a multiple of four. Bytes are always aligned.
    function automatic logic is_misaligned(input logic [1:0] order,
                                           input logic [1:0] addr_lo);
        case (order)
            2'd0:    is_misaligned = 1'b0;
            2'd1:    is_misaligned = addr_lo[0];
            default: is_misaligned = (addr_lo != 2'b00);
        endcase
    endfunction

    logic [2:0]  state_q,      state_d;
    logic        ldst_valid_q, ldst_valid_d;
    logic [31:0] ldst_data_q,  ldst_data_d;
    logic        ldst_fault_q, ldst_fault_d;

    logic        rw_q,     rw_d;
    logic [31:0] pdt_q,    pdt_d;
    logic [31:0] addr_q,   addr_d;
    logic [31:0] wdata_q,  wdata_d;
    logic [3:0]  mask_q,   mask_d;
    logic [13:0] asid_q,   asid_d;
    logic [1:0]  mmumod_q, mmumod_d;
    logic [2:0]  mmups_q,  mmups_d;

    logic flush;
    logic accept;
    logic local_fault;

    assign flush  = iRESET_SYNC | iEVENT_HOLD | iEVENT_END;
    assign accept = (state_q == ST_IDLE) && iLDST_REQ && !flush;

    // Only meaningful together with accept; the parameter removes the check.
    assign local_fault = (P_MISALIGN_CHECK != 0) &&
                         is_misaligned(iLDST_ORDER, iLDST_ADDR[1:0]);

    always_comb begin
        state_d      = state_q;
        ldst_data_d  = ldst_data_q;
        ldst_fault_d = ldst_fault_q;

        rw_d         = rw_q;
        pdt_d        = pdt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mask_d       = mask_q;
        asid_d       = asid_q;
        mmumod_d     = mmumod_q;
        mmups_d      = mmups_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    rw_d     = iLDST_RW;
                    pdt_d    = iLDST_PDT;
                    addr_d   = iLDST_ADDR;
                    wdata_d  = iLDST_DATA;
                    mask_d   = iLDST_MASK;
                    asid_d   = iLDST_ASID;
                    mmumod_d = iLDST_MMUMOD;
                    mmups_d  = iLDST_MMUPS;
                    if (local_fault) begin
                        // Fault is answered directly; the bus never sees it.
                        state_d      = ST_RESP;
                        ldst_data_d  = 32'h0;
                        ldst_fault_d = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end

            ST_REQ: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (!iDATA_BUSY) begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (iDATA_VALID) begin
                    if (flush) begin
                        // Bus finished in the same cycle: nothing left to drain.
                        state_d = ST_IDLE;
                    end else begin
                        state_d      = ST_RESP;
                        ldst_data_d  = rw_q ? 32'h0 : iDATA_DATA;
                        ldst_fault_d = 1'b0;
                    end
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            ST_DRAIN: begin
                // Further flushes are irrelevant here; only the bus matters.
                if (iDATA_VALID) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered so that the pulse coincides exactly with RESP.
        ldst_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            state_q      <= ST_IDLE;
            ldst_valid_q <= 1'b0;
            ldst_data_q  <= 32'h0;
            ldst_fault_q <= 1'b0;
            rw_q         <= 1'b0;
            pdt_q        <= 32'h0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            mask_q       <= 4'h0;
            asid_q       <= 14'h0;
            mmumod_q     <= 2'h0;
            mmups_q      <= 3'h0;
        end else begin
            state_q      <= state_d;
            ldst_valid_q <= ldst_valid_d;
            ldst_data_q  <= ldst_data_d;
            ldst_fault_q <= ldst_fault_d;
            rw_q         <= rw_d;
            pdt_q        <= pdt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mask_q       <= mask_d;
            asid_q       <= asid_d;
            mmumod_q     <= mmumod_d;
            mmups_q      <= mmups_d;
        end
    end

    assign oLDST_BUSY   = (state_q != ST_IDLE);
    assign oLDST_VALID  = ldst_valid_q;
    assign oLDST_DATA   = ldst_data_q;
    assign oLDST_FAULT  = ldst_fault_q;

    // A flush must suppress the bus request in the very cycle it arrives.
    assign oDATA_REQ    = (state_q == ST_REQ) && !iDATA_BUSY && !flush;

    assign oDATA_RW     = rw_q;
    assign oDATA_PDT    = pdt_q;
    assign oDATA_ADDR   = addr_q;
    assign oDATA_DATA   = wdata_q;
    assign oDATA_MASK   = mask_q;
    assign oDATA_ASID   = asid_q;
    assign oDATA_MMUMOD = mmumod_q;
    assign oDATA_MMUPS  = mmups_q;

endmodule
